// File: rtl/serial_tx_arbiter_if.sv
// rtl/serial_tx_arbiter_if.sv - requester/serializer bundle around serial_tx_arbiter
// Signal suffixes are from the arbiter's point of view.
interface serial_tx_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]            req_last_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic [DATA_WIDTH-1:0]         ser_data_o;
  logic                          ser_valid_o;
  logic                          ser_ready_i;
  logic [IDW-1:0]                ser_id_o;
  logic                          ser_last_o;
  logic                          busy_o;

  modport slave (
    input  req_valid_i, req_data_i, req_last_i, ser_ready_i,
    output req_ready_o, ser_data_o, ser_valid_o, ser_id_o, ser_last_o, busy_o
  );

  modport master (
    output req_valid_i, req_data_i, req_last_i, ser_ready_i,
    input  req_ready_o, ser_data_o, ser_valid_o, ser_id_o, ser_last_o, busy_o
  );
endinterface

// File: rtl/serial_tx_arbiter.sv
// rtl/serial_tx_arbiter.sv - packet round-robin arbiter feeding the serializer
// Grant is held for a whole packet; words pass through a one-entry output register.
module serial_tx_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  serial_tx_arbiter_if.slave  bus
);
  typedef enum logic {IDLE, LOCK} state_e;

  state_e                state_q, state_d;
  logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]        owner_q, owner_d;
  logic                  ser_valid_q, ser_valid_d;
  logic [DATA_WIDTH-1:0] ser_data_q, ser_data_d;
  logic [IDW-1:0]        ser_id_q, ser_id_d;
  logic                  ser_last_q, ser_last_d;

  logic                  buf_free;
  logic                  found;
  logic                  accept;
  logic                  sel_last;
  logic [IDW-1:0]        win;
  logic [IDW-1:0]        cand;
  logic [IDW-1:0]        sel;
  logic [IDW-1:0]        sel_next;
  logic [NUM_REQ-1:0]    grant;
  logic [DATA_WIDTH-1:0] sel_data;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      ser_valid_q <= 1'b0;
      ser_data_q  <= '0;
      ser_id_q    <= '0;
      ser_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      ser_valid_q <= ser_valid_d;
      ser_data_q  <= ser_data_d;
      ser_id_q    <= ser_id_d;
      ser_last_q  <= ser_last_d;
    end
  end

  always_comb begin
    buf_free = !ser_valid_q || bus.ser_ready_i;

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && bus.req_valid_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end

    sel      = (state_q == LOCK) ? owner_q : win;
    grant    = '0;
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDW'(i) == sel) begin
        grant[i] = 1'b1;
        sel_data = bus.req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        sel_last = bus.req_last_i[i];
      end
    end
    if (state_q == IDLE && !found) grant = '0;

    // Gating with rst_n_i keeps ready low for the whole reset, not just after the flops clear.
    bus.req_ready_o = (rst_n_i && buf_free) ? grant : '0;
    accept          = |(bus.req_ready_o & bus.req_valid_i);
    sel_next        = IDW'((int'(sel) + 1) % NUM_REQ);

    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    ser_valid_d = ser_valid_q;
    ser_data_d  = ser_data_q;
    ser_id_d    = ser_id_q;
    ser_last_d  = ser_last_q;

    if (accept) begin
      ser_valid_d = 1'b1;
      ser_data_d  = sel_data;
      ser_id_d    = sel;
      ser_last_d  = sel_last;
      if (sel_last) begin
        state_d  = IDLE;
        rr_ptr_d = sel_next;
      end else begin
        state_d = LOCK;
        owner_d = sel;
      end
    end else if (bus.ser_ready_i) begin
      ser_valid_d = 1'b0;
    end
  end

  assign bus.ser_valid_o = ser_valid_q;
  assign bus.ser_data_o  = ser_data_q;
  assign bus.ser_id_o    = ser_id_q;
  assign bus.ser_last_o  = ser_last_q;
  assign bus.busy_o      = (state_q == LOCK) || ser_valid_q;
endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb/tb_serial_tx_arbiter.sv - directed bench for serial_tx_arbiter with a packet-level model
module tb_serial_tx_arbiter;
  localparam int DW = 8;
  localparam int N  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_tx_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(N)) bus();
  serial_tx_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Per-requester packet sources
  logic [DW-1:0] qd [N][16];
  logic          ql [N][16];
  int            qh [N];
  int            qt [N];
  bit            en [N];
  logic          ser_rdy = 1'b1;
  logic [N-1:0]  acc_q = '0;

  task automatic push(int r, logic [DW-1:0] d, logic l);
    qd[r][qt[r]] = d;
    ql[r][qt[r]] = l;
    qt[r]++;
  endtask

  task automatic clear_srcs();
    for (int r = 0; r < N; r++) begin
      qh[r] = 0;
      qt[r] = 0;
    end
  endtask

  task automatic drive();
    logic [N-1:0]    v;
    logic [N-1:0]    l;
    logic [N*DW-1:0] d;
    v = '0; l = '0; d = '0;
    for (int r = 0; r < N; r++) begin
      if (qh[r] < qt[r]) begin
        d[r*DW +: DW] = qd[r][qh[r]];
        l[r]          = ql[r][qh[r]];
        v[r]          = en[r];
      end
    end
    bus.req_valid_i = v;
    bus.req_data_i  = d;
    bus.req_last_i  = l;
    bus.ser_ready_i = ser_rdy;
  endtask

  task automatic run(int n);
    repeat (n) begin
      drive();
      @(posedge clk);
      #1;
      for (int r = 0; r < N; r++) if (acc_q[r]) qh[r]++;
    end
  endtask

  // Packet-level model: owner == -1 means no packet in progress
  int            m_rr, m_own, m_id, cyc;
  bit            m_vld, m_last;
  logic [DW-1:0] m_data;
  int g_id[$], g_cyc[$], x_id[$], x_last[$], x_data[$], x_cyc[$];
  logic [N-1:0]    pv = '0, pr = '0, pl = '0;
  logic [N*DW-1:0] pd = '0;

  task automatic clr_logs();
    g_id.delete(); g_cyc.delete();
    x_id.delete(); x_last.delete(); x_data.delete(); x_cyc.delete();
  endtask

  always @(negedge clk) begin
    int           g;
    bit           free;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] v;
    cyc++;
    v     = bus.req_valid_i;
    acc_q = v & bus.req_ready_o;

    for (int r = 0; r < N; r++) begin
      if (rst_n && pv[r] && !pr[r] && v[r]) begin
        checks++;
        assert (bus.req_data_i[r*DW +: DW] == pd[r*DW +: DW] && bus.req_last_i[r] == pl[r])
        else begin
          errors++;
          $display("FAIL hold_stable req %0d: data changed while waiting", r);
        end
      end
    end
    pv = v; pr = bus.req_ready_o; pd = bus.req_data_i; pl = bus.req_last_i;

    if (!rst_n) begin
      m_rr = 0; m_own = -1; m_vld = 0; m_last = 0; m_data = '0; m_id = 0;
      chk("rst_req_ready", bus.req_ready_o, 0);
      chk("rst_ser_valid", bus.ser_valid_o, 0);
      chk("rst_ser_data", bus.ser_data_o, 0);
      chk("rst_ser_id", bus.ser_id_o, 0);
      chk("rst_ser_last", bus.ser_last_o, 0);
      chk("rst_busy", bus.busy_o, 0);
    end else begin
      chk("ser_valid", bus.ser_valid_o, m_vld);
      if (m_vld) begin
        chk("ser_data", bus.ser_data_o, m_data);
        chk("ser_id", bus.ser_id_o, m_id);
        chk("ser_last", bus.ser_last_o, m_last);
      end
      chk("busy", bus.busy_o, (m_own >= 0) || m_vld);

      free = !m_vld || ser_rdy;
      g = m_own;
      if (g < 0)
        for (int k = 0; k < N; k++)
          if (g < 0 && v[(m_rr + k) % N]) g = (m_rr + k) % N;
      exp_rdy = (g >= 0 && free) ? N'(1 << g) : '0;
      chk("req_ready", bus.req_ready_o, exp_rdy);
      chk("req_ready_onehot", $countones(bus.req_ready_o) <= 1, 1);

      if (m_vld && ser_rdy) begin
        x_id.push_back(m_id); x_last.push_back(m_last);
        x_data.push_back(m_data); x_cyc.push_back(cyc);
      end
      if (g >= 0 && free && v[g]) begin
        m_vld  = 1;
        m_data = bus.req_data_i[g*DW +: DW];
        m_id   = g;
        m_last = bus.req_last_i[g];
        g_id.push_back(g); g_cyc.push_back(cyc);
        if (m_last) begin
          m_own = -1;
          m_rr  = (g + 1) % N;
        end else begin
          m_own = g;
        end
      end else if (ser_rdy) begin
        m_vld = 0;
      end
    end
  end

  initial begin
    for (int r = 0; r < N; r++) en[r] = 1;
    clear_srcs();
    ser_rdy = 1;
    run(2);
    rst_n = 1;
    chk("post_reset_busy", bus.busy_o, 0);

    // Single requester 2, three-word packet
    clr_logs();
    push(2, 8'h21, 0); push(2, 8'h22, 0); push(2, 8'h23, 1);
    run(6);
    chk("s1_count", x_id.size(), 3);
    if (x_id.size() >= 3) begin
      chk("s1_id0", x_id[0], 2); chk("s1_id1", x_id[1], 2); chk("s1_id2", x_id[2], 2);
      chk("s1_last0", x_last[0], 0); chk("s1_last1", x_last[1], 0); chk("s1_last2", x_last[2], 1);
      chk("s1_data2", x_data[2], 8'h23);
      chk("s1_consec", x_cyc[2] - x_cyc[0], 2);
    end
    chk("s1_rr_model", m_rr, 3);

    // All four valid with one-word packets from a fresh pointer
    rst_n = 0; run(2); rst_n = 1;
    clr_logs();
    push(0, 8'h01, 1); push(0, 8'h05, 1); push(1, 8'h11, 1);
    push(2, 8'h2a, 1); push(3, 8'h31, 1);
    run(8);
    chk("s2_count", g_id.size(), 5);
    if (g_id.size() >= 5) begin
      chk("s2_g0", g_id[0], 0); chk("s2_g1", g_id[1], 1); chk("s2_g2", g_id[2], 2);
      chk("s2_g3", g_id[3], 3); chk("s2_g4", g_id[4], 0);
      chk("s2_rate", g_cyc[4] - g_cyc[0], 4);
    end
    if (x_data.size() >= 5) chk("s2_data4", x_data[4], 8'h05);

    // Requester 1 holds a 4-word packet while 0 stays valid
    clr_logs();
    push(1, 8'h41, 0); push(1, 8'h42, 0); push(1, 8'h43, 0); push(1, 8'h44, 1);
    push(0, 8'h0a, 1); push(0, 8'h0b, 1);
    run(10);
    chk("s3_count", g_id.size(), 6);
    if (g_id.size() >= 6) begin
      chk("s3_g0", g_id[0], 1); chk("s3_g3", g_id[3], 1); chk("s3_g4", g_id[4], 0);
      chk("s3_next", g_cyc[4] - g_cyc[3], 1);
    end

    // Serializer stall for five cycles
    clr_logs();
    ser_rdy = 0;
    push(3, 8'h31, 1); push(3, 8'h32, 1);
    run(6);
    chk("s4_hold_data", bus.ser_data_o, 8'h31);
    chk("s4_hold_id", bus.ser_id_o, 3);
    chk("s4_hold_valid", bus.ser_valid_o, 1);
    chk("s4_no_ready", bus.req_ready_o, 0);
    ser_rdy = 1;
    run(4);
    if (x_cyc.size() >= 1 && g_cyc.size() >= 2) begin
      chk("s4_same_cycle", g_cyc[1], x_cyc[0]);
      chk("s4_xdata", x_data[0], 8'h31);
    end else chk("s4_logs", x_cyc.size() * 10 + g_cyc.size(), 22);

    // Owner drops valid mid-packet
    clr_logs();
    push(0, 8'h50, 0); push(0, 8'h51, 0); push(0, 8'h52, 1);
    push(1, 8'h61, 1); push(2, 8'h62, 1);
    run(1);
    en[0] = 0;
    run(3);
    chk("s5_no_other", bus.req_ready_o & 4'b1110, 0);
    chk("s5_busy", bus.busy_o, 1);
    chk("s5_grants", g_id.size(), 1);
    en[0] = 1;
    run(8);
    chk("s5_count", g_id.size(), 5);
    if (g_id.size() >= 5) begin
      chk("s5_g2", g_id[2], 0); chk("s5_g3", g_id[3], 1); chk("s5_g4", g_id[4], 2);
    end

    // Asynchronous reset mid-packet
    clr_logs();
    push(2, 8'h71, 0); push(2, 8'h72, 0); push(2, 8'h73, 0); push(2, 8'h74, 1);
    run(2);
    chk("s6_pre_valid", bus.ser_valid_o, 1);
    rst_n = 0;
    #1;
    chk("s6_async_valid", bus.ser_valid_o, 0);
    chk("s6_async_busy", bus.busy_o, 0);
    chk("s6_async_ready", bus.req_ready_o, 0);
    chk("s6_async_data", bus.ser_data_o, 0);
    clear_srcs();
    push(0, 8'h81, 1); push(3, 8'h83, 1);
    run(2);
    rst_n = 1;
    clr_logs();
    run(5);
    chk("s6_count", g_id.size(), 2);
    if (g_id.size() >= 2) begin
      chk("s6_first", g_id[0], 0); chk("s6_second", g_id[1], 3);
    end
    run(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
